div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_pkg.sv | 22 ++
 rtl/div_seq_step.sv | 20 ++
 rtl/div_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: state encoding, iteration count,
// result field positions and a magnitude helper.
package div_seq_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [5:0] DIV_ITER = 6'd32;

   localparam int HI_MSB = 63;
   localparam int HI_LSB = 32;
   localparam int LO_MSB = 31;
   localparam int LO_LSB = 0;

   // Absolute value of a 32-bit operand; only negates when the operation is signed.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      if (sgn && v[31]) return 32'd0 - v;
      return v;
   endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes (purely combinational).
module div_step
   import div_seq_pkg::*;
(
   input  logic [31:0] rem_i,
   input  logic        bit_i,
   input  logic [31:0] dvs_i,
   output logic [31:0] rem_o,
   output logic        q_o
);

   logic [32:0] part;

   // Partial remainder is always below the divisor, so after a successful
   // subtract the difference fits back into 32 bits.
   assign part  = {rem_i, bit_i};
   assign q_o   = (part >= {1'b0, dvs_i});
   assign rem_o = q_o ? (part[31:0] - dvs_i) : part[31:0];

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit DIV/DIVU, one quotient bit per cycle, result in hilo format.
// Optional DIV_SEQ_ZERO_FAST_EN: a zero divisor completes straight from IDLE.
//
// state   | meaning
// IDLE    | waiting for start_i; operands latched on accept
// BUSY    | 32 restoring iterations, then one cycle of sign fix-up
// DONE    | ready_o pulse, result_o valid
module div_seq
   import div_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cancel_i,
   output logic        busy_o,
   output logic        ready_o,
   output logic [63:0] result_o
);

   logic [1:0]  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        sgn_q, sgn_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [63:0] res_q, res_d;

   logic [31:0] dvs;
   logic [31:0] step_rem;
   logic        step_q;
   logic [31:0] q_fix;
   logic [31:0] r_fix;
   logic        accept;

   assign dvs    = mag32(b_q, sgn_q);
   assign accept = start_i && !cancel_i;

   div_step u_step (
      .rem_i (rem_q),
      .bit_i (quo_q[31]),
      .dvs_i (dvs),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   // Quotient negates on differing signs; remainder follows the dividend's sign.
   assign q_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'd0 - quo_q) : quo_q;
   assign r_fix = (sgn_q && a_q[31]) ? (32'd0 - rem_q) : rem_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d   = a_i;
               b_d   = b_i;
               sgn_d = signed_i;
               cnt_d = 6'd0;
               rem_d = 32'd0;
               quo_d = mag32(a_i, signed_i);
`ifdef DIV_SEQ_ZERO_FAST_EN
               if (b_i == 32'd0) begin
                  state_d                = ST_DONE;
                  res_d[HI_MSB:HI_LSB]   = a_i;
                  res_d[LO_MSB:LO_LSB]   = 32'hFFFF_FFFF;
               end else begin
                  state_d = ST_BUSY;
               end
`else
               state_d = ST_BUSY;
`endif
            end
         end
         ST_BUSY: begin
            if (cancel_i) begin
               state_d = ST_IDLE;
            end else if (cnt_q == DIV_ITER) begin
               state_d = ST_DONE;
               if (b_q == 32'd0) begin
                  res_d[HI_MSB:HI_LSB] = a_q;
                  res_d[LO_MSB:LO_LSB] = 32'hFFFF_FFFF;
               end else begin
                  res_d[HI_MSB:HI_LSB] = r_fix;
                  res_d[LO_MSB:LO_LSB] = q_fix;
               end
            end else begin
               rem_d = step_rem;
               quo_d = {quo_q[30:0], step_q};
               cnt_d = cnt_q + 6'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 6'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         sgn_q   <= 1'b0;
         rem_q   <= 32'd0;
         quo_q   <= 32'd0;
         res_q   <= 64'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
      end
   end

   assign busy_o   = (state_q == ST_BUSY) || ((state_q == ST_IDLE) && accept);
   assign ready_o  = (state_q == ST_DONE) && !cancel_i;
   assign result_o = res_q;

endmodule
